prog_mem_sequencer: RTL
=======================

// Module: prog_mem_sequencer
// PURPOSE
//  Owns the 16x4 program memory that feeds the 4-bit nibble CPU's mem_in bus.
//  Shares that memory between a serial loader (host writes program nibbles) and CPU fetch.
//  Holds the CPU in reset while loading, then boots it. Sits beside the CPU inside the TinyTapeout top.
// PARAMETERS
//  ADDR_W   4   CPU address / write-pointer width
//  DATA_W   4   nibble width
//  DEPTH    16  memory words; must equal 2**ADDR_W
//  BOOT_CYC 2   cycles cpu_reset stays high in BOOT; must be >= 1
// PORTS
//  clk         in   1       single clock, shared with the CPU
//  reset       in   1       synchronous, active-high
//  cpu_addr    in   ADDR_W  CPU mem_request
//  cpu_data    out  DATA_W  nibble to CPU mem_in
//  cpu_reset   out  1       drives the CPU reset input
//  ld_start    in   1       pulse: begin (or restart) a program load
//  ld_valid    in   1       loader nibble valid
//  ld_ready    out  1       controller accepts a nibble
//  ld_data     in   DATA_W  program nibble
//  ld_last     in   1       qualifies the final nibble (with ld_valid)
//  state_o     out  2       current FSM state (debug)
//  ld_count    out  ADDR_W+1  nibbles written in the current or last load
// BEHAVIOUR
//  Reset (sync, highest priority): state=IDLE; all memory words=0 (opcode 0 = no-op);
//   cpu_reset=1; ld_ready=0; ld_count=0; wptr=0; cpu_data reads 0.
//  FSM states: IDLE(0) LOAD(1) BOOT(2) RUN(3).
//   IDLE: cpu_reset=1. ld_start -> LOAD.
//   LOAD: cpu_reset=1; ld_ready=1. Beat = ld_valid&&ld_ready: mem[wptr]<=ld_data, wptr++, ld_count++.
//    Beat with ld_last, or beat at wptr==DEPTH-1 -> BOOT (wptr wraps to 0, no overwrite).
//   BOOT: cpu_reset=1, ld_ready=0, exactly BOOT_CYC cycles, then -> RUN.
//   RUN: cpu_reset=0; ld_ready=0. ld_start -> LOAD, with cpu_reset=1 on the next cycle.
//  ld_start in LOAD restarts: wptr=0, ld_count=0; a same-cycle beat is dropped (start wins).
//  On LOAD entry, wptr=0 and ld_count=0. Earlier words stay until overwritten.
//  ld_valid outside LOAD is ignored; memory is unchanged.
//  cpu_data = mem[cpu_addr]: combinational, zero latency. The CPU samples it one cycle after driving the address.
//  A written word is visible on cpu_data the cycle after the beat.
//  ld_count saturates at DEPTH. It holds after BOOT until the next LOAD entry.
//  Reset mid-LOAD or mid-RUN: full reset, memory cleared, CPU held.
// CONFIGURATION
//  LD_CHECKSUM_EN defined:
//   - Keep a running DATA_W-bit modulo sum of the nibbles accepted in the current load.
//   - After the ld_last beat, the controller expects one extra beat carrying the checksum nibble (not written to memory).
//   - Match -> BOOT. Mismatch -> IDLE, with cpu_reset=1 and the memory retained.
//   - The checksum beat is only taken after ld_last; the DEPTH auto-end still occurs but then also waits for it.
//  LD_CHECKSUM_EN undefined: no checksum beat; ld_last/DEPTH go straight to BOOT.
// STRUCTURE
//  prog_mem_pkg:
//   - state enum (IDLE/LOAD/BOOT/RUN)
//   - ADDR_W/DATA_W/DEPTH defaults
//   - NOP opcode constant (4'h0)
//  Sub-module prog_mem_array: DEPTH x DATA_W register file.
//   - One sync write port, one async read port, sync clear on reset.
//  The top holds the FSM, wptr, ld_count, BOOT counter and the optional checksum.
// TESTING
//  1. Reset: check state_o=0, cpu_reset=1, ld_ready=0, and cpu_data=0 for cpu_addr 0..15.
//  2. ld_start, then 3 beats 1,2,1 with ld_last on the 3rd.
//     Expect mem[0..2]=1,2,1 and ld_count=3. Then BOOT for 2 cycles with cpu_reset=1.
//     Then RUN with cpu_reset=0 and cpu_addr=1 -> cpu_data=2.
//  3. Load 16 beats with no ld_last -> auto BOOT after beat 16; ld_count=16; a 17th ld_valid is ignored.
//  4. In RUN assert ld_start -> cpu_reset=1 the next cycle and ld_ready=1.
//     In LOAD, ld_start together with ld_valid(data 7) -> beat dropped, wptr=0.
//  5. Reset asserted mid-LOAD after 5 beats -> IDLE, memory all 0, ld_count=0.
//  6. With LD_CHECKSUM_EN: load 3,4 with ld_last, then checksum 7 -> RUN.
//     Same load with checksum 6 -> IDLE, cpu_reset stays 1, mem[0..1]=3,4.

Source files
------------

// File: rtl/prog_mem_pkg.sv
// Shared types and defaults for the nibble-CPU program memory sequencer.
// Holds the FSM state encoding, the default geometry and the no-op opcode used to clear memory.
package prog_mem_pkg;

    localparam int PM_ADDR_W   = 4;
    localparam int PM_DATA_W   = 4;
    localparam int PM_DEPTH    = 16;
    localparam int PM_BOOT_CYC = 2;

    localparam logic [3:0] PM_NOP = 4'h0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_BOOT = 2'd2,
        ST_RUN  = 2'd3
    } pm_state_e;

endpackage

// File: rtl/prog_mem_array.sv
// DEPTH x DATA_W register file: one synchronous write port, one combinational read port.
// Synchronous reset clears every word to the no-op opcode.
module prog_mem_array
    import prog_mem_pkg::*;
#(
    parameter int ADDR_W = PM_ADDR_W,
    parameter int DATA_W = PM_DATA_W,
    parameter int DEPTH  = PM_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_reg [DEPTH];
    logic [DEPTH-1:0]  word_we;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_word_we
            assign word_we[gi] = we && (waddr == ADDR_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (reset) begin
                mem_reg[i] <= DATA_W'(PM_NOP);
            end else if (word_we[i]) begin
                mem_reg[i] <= wdata;
            end
        end
    end

    // Zero-latency read: the CPU samples mem_in one cycle after driving its address.
    assign rdata = mem_reg[raddr];

endmodule

// File: rtl/prog_mem_sequencer.sv
// Program memory owner for the nibble CPU: serial loader, boot sequencing and CPU fetch port.
// Optional LD_CHECKSUM_EN adds a trailing checksum beat that must match before booting.
module prog_mem_sequencer
    import prog_mem_pkg::*;
#(
    parameter int ADDR_W   = PM_ADDR_W,
    parameter int DATA_W   = PM_DATA_W,
    parameter int DEPTH    = PM_DEPTH,
    parameter int BOOT_CYC = PM_BOOT_CYC
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic [DATA_W-1:0] cpu_data,
    output logic              cpu_reset,
    input  logic              ld_start,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic [1:0]        state_o,
    output logic [ADDR_W:0]   ld_count
);

    localparam int CNT_W = ADDR_W + 1;
    localparam int BC_W  = (BOOT_CYC > 1) ? $clog2(BOOT_CYC) : 1;

    pm_state_e         state_reg, state_next;
    logic [ADDR_W-1:0] wptr_reg;
    logic [CNT_W-1:0]  count_reg;
    logic [BC_W-1:0]   boot_cnt_reg;

    logic load_start;
    logic beat;
    logic data_beat;
    logic load_end;
    logic boot_done;

    // A start pulse while booting is ignored; everywhere else it (re)opens a load.
    assign load_start = ld_start && (state_reg != ST_BOOT);
    assign beat       = ld_valid && ld_ready && !ld_start;
    assign boot_done  = (boot_cnt_reg == BC_W'(BOOT_CYC - 1));

`ifdef LD_CHECKSUM_EN
    logic              ck_wait_reg;
    logic [DATA_W-1:0] sum_reg;
    logic              ck_beat;

    assign data_beat = beat && !ck_wait_reg;
    assign ck_beat   = beat && ck_wait_reg;
`else
    assign data_beat = beat;
`endif

    assign load_end = data_beat && (ld_last || (wptr_reg == ADDR_W'(DEPTH - 1)));

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (ld_start) state_next = ST_LOAD;
            end
            ST_LOAD: begin
                if (ld_start) begin
                    state_next = ST_LOAD;
`ifdef LD_CHECKSUM_EN
                end else if (ck_beat) begin
                    state_next = (ld_data == sum_reg) ? ST_BOOT : ST_IDLE;
`else
                end else if (load_end) begin
                    state_next = ST_BOOT;
`endif
                end
            end
            ST_BOOT: begin
                if (boot_done) state_next = ST_RUN;
            end
            ST_RUN: begin
                if (ld_start) state_next = ST_LOAD;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Outputs decoded from the current state
    always_comb begin
        cpu_reset = 1'b1;
        ld_ready  = 1'b0;
        case (state_reg)
            ST_LOAD: ld_ready  = 1'b1;
            ST_RUN:  cpu_reset = 1'b0;
            default: begin
                cpu_reset = 1'b1;
                ld_ready  = 1'b0;
            end
        endcase
    end

    // Write pointer, beat counter and boot timer
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_reg     <= '0;
            count_reg    <= '0;
            boot_cnt_reg <= '0;
        end else begin
            if (load_start) begin
                wptr_reg  <= '0;
                count_reg <= '0;
            end else if (data_beat) begin
                wptr_reg <= wptr_reg + 1'b1;
                if (count_reg != CNT_W'(DEPTH)) begin
                    count_reg <= count_reg + 1'b1;
                end
            end
            boot_cnt_reg <= (state_reg == ST_BOOT) ? boot_cnt_reg + 1'b1 : '0;
        end
    end

`ifdef LD_CHECKSUM_EN
    // Running modulo sum; ck_wait_reg marks that only the checksum beat is still owed.
    always_ff @(posedge clk) begin
        if (reset) begin
            ck_wait_reg <= 1'b0;
            sum_reg     <= '0;
        end else if (load_start) begin
            ck_wait_reg <= 1'b0;
            sum_reg     <= '0;
        end else if (data_beat) begin
            sum_reg <= sum_reg + ld_data;
            if (load_end) ck_wait_reg <= 1'b1;
        end else if (ck_beat) begin
            ck_wait_reg <= 1'b0;
        end
    end
`endif

    prog_mem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk   (clk),
        .reset (reset),
        .we    (data_beat),
        .waddr (wptr_reg),
        .wdata (ld_data),
        .raddr (cpu_addr),
        .rdata (cpu_data)
    );

    assign state_o  = state_reg;
    assign ld_count = count_reg;

endmodule
